// File: rtl/uart_dump_pkg.sv
// Shared constants, state encodings and ASCII helper for the register-file UART dump.
package uart_dump_pkg;

    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam int         NUM_CHARS = 26;

    // Serial transmitter states (FETCH is the sequencer's per-character setup slot).
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
        ST_STOP
    } dump_state_e;

    // Character sequencer states.
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_FETCH,
        SEQ_SEND
    } seq_state_e;

    // 0-9 -> '0'-'9', A-F -> 'A'-'F'.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, each BAUD_DIV cycles.
//
// state    | meaning
// ST_IDLE  | line idle high, waiting for load
// ST_START | start bit (0) on the line
// ST_DATA  | data bits, LSB first
// ST_STOP  | stop bit (1) on the line
module uart_tx_8n1
    import uart_dump_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       load,
    output logic       txd,
    output logic       tx_busy
);

    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(BAUD_DIV - 1);

    dump_state_e      state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;

    // Busy drops during the last cycle of the stop bit so the sequencer can advance on the
    // same edge that ends the character, keeping each character at exactly 10 bit times.
    assign tx_busy = (state != ST_IDLE) && !((state == ST_STOP) && (baud_cnt == '0));

    // Bit sequencing with a terminal-count down-counter per bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state    <= ST_START;
                        shreg    <= data;
                        baud_cnt <= DIV_LAST;
                        txd      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_cnt == '0) begin
                        state    <= ST_DATA;
                        baud_cnt <= DIV_LAST;
                        bit_cnt  <= 3'd7;
                        txd      <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= DIV_LAST;
                        if (bit_cnt == 3'd0) begin
                            state <= ST_STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                            txd     <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == '0)
                        state <= ST_IDLE;
                    else
                        baud_cnt <= baud_cnt - 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/regfile_uart_dump.sv
// Sweeps the 8x8 register file and sends it as "HH HH ... HH \r\n" over UART 8N1.
//
// state     | meaning
// SEQ_IDLE  | waiting for start, ra held at 0
// SEQ_FETCH | one-cycle setup: sample rd on hi characters, hand the character to the tx
// SEQ_SEND  | character on the wire, wait for the end of its stop bit
module regfile_uart_dump
    import uart_dump_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [2:0] ra,
    input  logic [7:0] rd,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] IDX_CR = 5'(NUM_CHARS - 2);
    localparam logic [4:0] IDX_LF = 5'(NUM_CHARS - 1);

    seq_state_e state;
    logic [4:0] char_idx;
    logic [1:0] pos;
    logic [7:0] snap;
    logic [7:0] cur_byte;
    logic [7:0] tx_data;
    logic       load;
    logic       tx_busy;

    assign load = (state == SEQ_FETCH);

    // Hi characters read rd live (the snapshot is taken on the same edge); lo uses the snapshot.
    always_comb begin
        cur_byte = (pos == 2'd0) ? rd : snap;
        tx_data  = ASCII_SP;
        if (char_idx == IDX_CR)
            tx_data = ASCII_CR;
        else if (char_idx == IDX_LF)
            tx_data = ASCII_LF;
        else if (pos == 2'd0)
            tx_data = nibble_to_ascii(cur_byte[7:4]);
        else if (pos == 2'd1)
            tx_data = nibble_to_ascii(cur_byte[3:0]);
    end

    // Character sequencer, read address, snapshot and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEQ_IDLE;
            char_idx <= '0;
            pos      <= '0;
            snap     <= '0;
            ra       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (start) begin
                        state    <= SEQ_FETCH;
                        busy     <= 1'b1;
                        char_idx <= '0;
                        pos      <= '0;
                    end
                end
                SEQ_FETCH: begin
                    state <= SEQ_SEND;
                    if ((pos == 2'd0) && (char_idx < IDX_CR)) begin
                        snap <= rd;
                        ra   <= ra + 3'd1;
                    end
                end
                SEQ_SEND: begin
                    if (!tx_busy) begin
                        if (char_idx == IDX_LF) begin
                            state <= SEQ_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= SEQ_FETCH;
                            char_idx <= char_idx + 5'd1;
                            pos      <= (pos == 2'd2) ? 2'd0 : pos + 2'd1;
                        end
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

    uart_tx_8n1 #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .data   (tx_data),
        .load   (load),
        .txd    (txd),
        .tx_busy(tx_busy)
    );

endmodule

// File: tb/tb_regfile_uart_dump.sv
// Bench for regfile_uart_dump: register-file model on ra/rd, UART receiver, frame reference model.
module tb_regfile_uart_dump;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] ra;
    logic [7:0] rd;
    logic       txd;
    logic       busy;
    logic       done;

    logic [7:0] regs [8];
    assign rd = regs[ra];

    regfile_uart_dump #(.CLK_HZ(10), .BAUD(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .ra   (ra),
        .rd   (rd),
        .txd  (txd),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         frame_err = 0;
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] rx_byte;

    // UART receiver: samples mid-bit, 10 clocks per bit.
    initial begin
        forever begin
            @(negedge txd);
            repeat (15) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                rx_byte[i] = txd;
                if (i < 7) repeat (10) @(posedge clk);
            end
            repeat (10) @(posedge clk);
            if (txd !== 1'b1) frame_err++;
            rx_q.push_back(rx_byte);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] hex(input logic [3:0] d);
        return (d < 4'd10) ? 8'd48 + 8'(d) : 8'd55 + 8'(d);
    endfunction

    task automatic push_frame();
        for (int n = 0; n < 8; n++) begin
            exp_q.push_back(hex(regs[n][7:4]));
            exp_q.push_back(hex(regs[n][3:0]));
            exp_q.push_back(8'h20);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic check_frames(input string tag);
        int n;
        chk({tag, "_len"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic adv_to(inout int k, input int tgt);
        while (k < tgt) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_done(inout int k, output logic busy_prev);
        busy_prev = busy;
        while (done !== 1'b1 && k < 3000) begin
            busy_prev = busy;
            @(negedge clk);
            k++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    task automatic pulse_start(output int k);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
    endtask

    task automatic rand_regs();
        for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
    endtask

    int         k;
    logic       bprev;
    logic [7:0] ch0;
    logic       expb;
    int         seen_done;

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ra", ra, 3'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_txd", txd, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_ra", ra, 3'd0);

        // Directed frame, first-character bit timing, ignored mid-dump start
        regs[0] = 8'h3C;
        regs[1] = 8'hA5;
        push_frame();
        ch0 = hex(regs[0][7:4]);
        pulse_start(k);
        chk("fetch0_txd", txd, 1'b1);
        chk("fetch0_ra", ra, 3'd0);
        chk("fetch0_busy", busy, 1'b1);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            k++;
            if (c <= 10) expb = 1'b0;
            else if (c <= 90) expb = ch0[(c - 11) / 10];
            else expb = 1'b1;
            chk($sformatf("bit_c%0d", c), txd, expb);
            if (c == 1) chk("ra_after_fetch0", ra, 3'd1);
        end
        adv_to(k, 500);
        start = 1'b1;
        @(negedge clk);
        k++;
        start = 1'b0;
        wait_done(k, bprev);
        chk("done_cycle", k, 2626);
        chk("busy_before_done", bprev, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        chk("ra_at_done", ra, 3'd0);
        @(negedge clk);
        chk("done_width", done, 1'b0);
        repeat (30) @(negedge clk);
        chk("no_requeue_busy", busy, 1'b0);
        check_frames("frame1");

        // start held high: back-to-back frames with random contents
        rand_regs();
        push_frame();
        push_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        k = 0;
        wait_done(k, bprev);
        chk("hold_done_cycle", k, 2626);
        @(negedge clk);
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_fetch_txd", txd, 1'b1);
        chk("b2b_fetch_ra", ra, 3'd0);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        chk("b2b_start_bit", txd, 1'b0);
        wait_done(k, bprev);
        chk("b2b_done_cycle", k, 2626);
        repeat (5) @(negedge clk);
        check_frames("b2b");

        // Write reg1 during its hi character: snapshot holds the old value
        rand_regs();
        regs[1] = 8'hA5;
        push_frame();
        pulse_start(k);
        adv_to(k, 320);
        regs[1] = 8'hFF;
        wait_done(k, bprev);
        repeat (5) @(negedge clk);
        check_frames("tear");
        push_frame();
        pulse_start(k);
        wait_done(k, bprev);
        repeat (5) @(negedge clk);
        check_frames("after_write");

        // Reset mid-data-bit of character 7
        rand_regs();
        pulse_start(k);
        adv_to(k, 750);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_txd", txd, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ra", ra, 3'd0);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        rst_n = 1'b1;
        repeat (150) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);
        chk("abort_idle_busy", busy, 1'b0);
        rx_q.delete();
        exp_q.delete();
        push_frame();
        pulse_start(k);
        wait_done(k, bprev);
        chk("restart_done_cycle", k, 2626);
        repeat (5) @(negedge clk);
        check_frames("restart");

        chk("stop_bits", frame_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_uart_dump.md
Name: regfile_uart_dump

Overview:
- Downstream consumer of the 8x8-bit register file's read port.
- On a start request, sweeps read addresses 0..7 and samples each register's read data.
- Transmits the whole register file over UART 8N1 as ASCII hex text: "HH HH HH HH HH HH HH HH \r\n".
- Lets the board-level test top dump register contents to a PC on UART_TXD instead of reading only two registers on the 7-segment displays.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- Derived constant BAUD_DIV = CLK_HZ/BAUD (integer division, must be >= 2): clock cycles per serial bit.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  dump request, sampled only in IDLE.
- ra  output  3  read address driven to the register file read port.
- rd  input  8  read data from the register file; combinational function of ra.
- txd  output  1  UART serial out, idle high.
- busy  output  1  high from the edge that accepts start until the dump completes.
- done  output  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (async, rst_n=0):
  - txd=1, busy=0, done=0, ra=0, state=IDLE, all counters 0.
  - Takes effect immediately, including mid-character. A partial character is abandoned and is not resumed.
- IDLE:
  - txd=1, busy=0, ra=0.
  - start=1 at an edge moves to FETCH and sets busy=1.
- Character sequence, 26 characters:
  - For each register n=0..7: hi nibble, lo nibble, space (0x20).
  - Then CR (0x0D), then LF (0x0A).
  - Nibble to ASCII: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46 (uppercase).
- Per-character timing:
  - One FETCH cycle (txd=1), then START bit, 8 DATA bits LSB first, and STOP bit (1).
  - Each bit lasts exactly BAUD_DIV cycles.
  - Cost per character is 1+10*BAUD_DIV cycles.
- Sampling:
  - During the FETCH of register n's hi character, ra=n; rd is captured into an 8-bit snapshot.
  - The same edge increments ra modulo 8.
  - The lo character uses the snapshot, so register-file writes after the sample never tear a byte.
  - FETCH for space, CR and LF samples nothing.
- Completion:
  - The edge ending LF's stop bit returns the block to IDLE with busy=0 and done=1 for exactly one cycle.
  - ra has wrapped to 0 by then.
  - Total from the accepting edge to the done edge: 26*(1+10*BAUD_DIV) cycles.
- start while busy is ignored, with no queueing. If start is still high in the cycle done is high, a new dump is accepted at the next edge.
- txd is a registered output, so there are no glitches.

Decomposition:
- Shared package (uart_dump_pkg):
  - Constants ASCII_SP=8'h20, ASCII_CR=8'h0D, ASCII_LF=8'h0A, NUM_CHARS=26.
  - State encoding IDLE/FETCH/START/DATA/STOP.
  - Function nibble_to_ascii.
- Natural sub-module: uart_tx_8n1.
  - Inputs: clk, rst_n, parameters CLK_HZ/BAUD, data[7:0], load. Outputs: txd, tx_busy.
  - Owns the baud counter and bit counter.
  - The top owns the character sequencer, ra, snapshot, busy and done.

Test Plan (bench uses CLK_HZ=10, BAUD=1, so BAUD_DIV=10 and 101 cycles/char):
1. Assert rst_n=0 -> txd=1, busy=0, done=0, ra=0. Release -> outputs unchanged while start=0.
2. Preload reg0=8'h3C, reg1=8'hA5, others 8'h00. Pulse start for 1 cycle -> UART decoder receives 0x33 0x43 0x20 0x41 0x35 0x20, then six repetitions of 0x30 0x30 0x20, then 0x0D 0x0A. done is high exactly 2626 cycles after the accepting edge; busy falls on the same edge.
3. Bit timing of the first character (0x33) -> txd=1 for 1 cycle, 0 for 10, bits 1,1,0,0,1,1,0,0 each 10 cycles, then 1 for 10. ra=0 at the first FETCH and ra=1 after it.
4. Pulse start at cycle 500 of a dump -> ignored; a single frame of 26 characters only. Hold start high continuously -> the second frame's FETCH begins the cycle after done.
5. Write reg1 from 8'hA5 to 8'hFF during reg1's hi character -> received "A5", not "AF". The next dump shows "FF".
6. Drop rst_n mid-data-bit of character 7 -> txd=1 and busy=0 asynchronously, with no done pulse. After release and a start, the full 26-character frame is sent from reg0.
